// File: rtl/l1_cache_ctrl_assoc_if.sv
// CPU/SRAM/DRAM-side signal bundle of the set-associative L1 cache controller.
// The master side is the surrounding pipeline/memory; the slave side is the controller.
interface l1_cache_ctrl_assoc_if #(
  parameter int WAYS      = 2,
  parameter int BURST_LEN = 4
);
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  logic              cpu_req;
  logic              cpu_we;
  logic              cpu_ack;
  logic [WAYS-1:0]   hit_vec;
  logic [WAYS-1:0]   valid_vec;
  logic [WAYS-1:0]   dirty_vec;
  logic [WAY_W-1:0]  way_sel;
  logic              sram_we;
  logic              sram_data_sel;
  logic              tag_we;
  logic              valid_o;
  logic              dirty_o;
  logic [BEAT_W-1:0] beat;
  logic              dram_cs;
  logic              dram_we;
  logic              dram_addr_sel;
  logic              dram_ack;

  modport master (
    output cpu_req, cpu_we, hit_vec, valid_vec, dirty_vec, dram_ack,
    input  cpu_ack, way_sel, sram_we, sram_data_sel, tag_we, valid_o, dirty_o,
           beat, dram_cs, dram_we, dram_addr_sel
  );

  modport slave (
    input  cpu_req, cpu_we, hit_vec, valid_vec, dirty_vec, dram_ack,
    output cpu_ack, way_sel, sram_we, sram_data_sel, tag_we, valid_o, dirty_o,
           beat, dram_cs, dram_we, dram_addr_sel
  );
endinterface

// File: rtl/l1_cache_ctrl_assoc.sv
// N-way set-associative L1 cache controller: hit/miss sequencing, victim selection
// (invalid-first, then round-robin) and multi-beat write-back / fill bursts to DRAM.
//
// state       | meaning
// IDLE        | waiting for cpu_req
// COMPARE     | tag compare, hit ack or victim choice
// WB          | write dirty victim line to DRAM, one beat per dram_ack
// FILL        | read line from DRAM into SRAM, one beat per dram_ack
// FILL_DONE   | write tag/valid for the filled way
// RESP        | ack the CPU
// WRITE_HIT   | write CPU word into SRAM and update tag/dirty
// WT_MEM      | write-through word to DRAM
module l1_cache_ctrl_assoc #(
  parameter int WAYS       = 2,
  parameter int BURST_LEN  = 4,
  parameter int WRITE_BACK = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  l1_cache_ctrl_assoc_if.slave  bus
);
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [WAY_W-1:0]  LAST_WAY  = WAY_W'(WAYS - 1);
  localparam logic              WB_EN     = (WRITE_BACK != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_COMPARE, S_WB, S_FILL, S_FILL_DONE, S_RESP, S_WRITE_HIT, S_WT_MEM
  } state_t;

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [WAY_W-1:0]  rr_q, rr_d;
  logic [WAY_W-1:0]  way_q, way_d;
  logic              we_q, we_d;
  logic              from_rr_q, from_rr_d;

  logic              hit, has_inv, rr_dirty, need_wb;
  logic [WAY_W-1:0]  hit_way, inv_way, victim;

  logic              cpu_ack, sram_we, sram_data_sel, tag_we, valid_o, dirty_o;
  logic              dram_cs, dram_we, dram_addr_sel;
  logic [WAY_W-1:0]  way_sel;

  // Scanning from the top index down leaves the lowest matching index selected.
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    has_inv  = 1'b0;
    inv_way  = '0;
    rr_dirty = 1'b0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (bus.hit_vec[i] && bus.valid_vec[i]) begin
        hit     = 1'b1;
        hit_way = WAY_W'(i);
      end
      if (!bus.valid_vec[i]) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(i);
      end
      if (WAY_W'(i) == rr_q) rr_dirty = bus.dirty_vec[i];
    end
    victim  = has_inv ? inv_way : rr_q;
    need_wb = WB_EN && !has_inv && rr_dirty;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      rr_q      <= '0;
      way_q     <= '0;
      we_q      <= 1'b0;
      from_rr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      rr_q      <= rr_d;
      way_q     <= way_d;
      we_q      <= we_d;
      from_rr_q <= from_rr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    rr_d          = rr_q;
    way_d         = way_q;
    we_d          = we_q;
    from_rr_d     = from_rr_q;
    cpu_ack       = 1'b0;
    sram_we       = 1'b0;
    sram_data_sel = 1'b0;
    tag_we        = 1'b0;
    valid_o       = 1'b0;
    dirty_o       = 1'b0;
    dram_cs       = 1'b0;
    dram_we       = 1'b0;
    dram_addr_sel = 1'b0;
    way_sel       = way_q;
    unique case (state_q)
      S_IDLE: begin
        way_sel = '0;
        if (bus.cpu_req) begin
          we_d    = bus.cpu_we;
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (hit) begin
          way_sel = hit_way;
          way_d   = hit_way;
          if (we_q) state_d = S_WRITE_HIT;
          else begin
            cpu_ack = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          way_sel   = victim;
          way_d     = victim;
          from_rr_d = !has_inv;
          state_d   = need_wb ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        dram_cs       = 1'b1;
        dram_we       = 1'b1;
        dram_addr_sel = 1'b1;
        if (bus.dram_ack) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = S_FILL;
          end else beat_d = beat_q + 1'b1;
        end
      end
      S_FILL: begin
        dram_cs       = 1'b1;
        sram_data_sel = 1'b1;
        sram_we       = bus.dram_ack;
        if (bus.dram_ack) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = S_FILL_DONE;
          end else beat_d = beat_q + 1'b1;
        end
      end
      S_FILL_DONE: begin
        tag_we  = 1'b1;
        valid_o = 1'b1;
        if (from_rr_q) rr_d = (rr_q == LAST_WAY) ? '0 : rr_q + 1'b1;
        state_d = we_q ? S_WRITE_HIT : S_RESP;
      end
      S_RESP: begin
        cpu_ack = 1'b1;
        state_d = S_IDLE;
      end
      S_WRITE_HIT: begin
        sram_we = 1'b1;
        tag_we  = 1'b1;
        valid_o = 1'b1;
        dirty_o = WB_EN;
        if (WB_EN) begin
          cpu_ack = 1'b1;
          state_d = S_IDLE;
        end else state_d = S_WT_MEM;
      end
      S_WT_MEM: begin
        dram_cs = 1'b1;
        dram_we = 1'b1;
        if (bus.dram_ack) state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.cpu_ack       = cpu_ack;
  assign bus.way_sel       = way_sel;
  assign bus.sram_we       = sram_we;
  assign bus.sram_data_sel = sram_data_sel;
  assign bus.tag_we        = tag_we;
  assign bus.valid_o       = valid_o;
  assign bus.dirty_o       = dirty_o;
  assign bus.beat          = beat_q;
  assign bus.dram_cs       = dram_cs;
  assign bus.dram_we       = dram_we;
  assign bus.dram_addr_sel = dram_addr_sel;
endmodule

// File: tb/tb_l1_cache_ctrl_assoc.sv
// Directed bench for l1_cache_ctrl_assoc: a write-back and a write-through instance,
// both WAYS=2, BURST_LEN=4.
module tb_l1_cache_ctrl_assoc;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  l1_cache_ctrl_assoc_if #(.WAYS(2), .BURST_LEN(4)) ia ();
  l1_cache_ctrl_assoc_if #(.WAYS(2), .BURST_LEN(4)) ib ();

  l1_cache_ctrl_assoc #(.WAYS(2), .BURST_LEN(4), .WRITE_BACK(1)) dut_wb (
    .clk(clk), .rst(rst), .bus(ia)
  );
  l1_cache_ctrl_assoc #(.WAYS(2), .BURST_LEN(4), .WRITE_BACK(0)) dut_wt (
    .clk(clk), .rst(rst), .bus(ib)
  );

  wire [11:0] outs_a = {ia.cpu_ack, ia.way_sel, ia.sram_we, ia.sram_data_sel, ia.tag_we,
                        ia.valid_o, ia.dirty_o, ia.beat, ia.dram_cs, ia.dram_we, ia.dram_addr_sel};
  wire [11:0] outs_b = {ib.cpu_ack, ib.way_sel, ib.sram_we, ib.sram_data_sel, ib.tag_we,
                        ib.valid_o, ib.dirty_o, ib.beat, ib.dram_cs, ib.dram_we, ib.dram_addr_sel};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change at posedge+1, outputs are sampled at posedge+3.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    ia.cpu_req = 1'b1; ia.cpu_we = 1'b0; ia.hit_vec = 2'b00; ia.valid_vec = 2'b00;
    ia.dirty_vec = 2'b00; ia.dram_ack = 1'b1;
    ib.cpu_req = 1'b1; ib.cpu_we = 1'b0; ib.hit_vec = 2'b00; ib.valid_vec = 2'b00;
    ib.dirty_vec = 2'b00; ib.dram_ack = 1'b1;

    // 1: reset held with request and ack active
    for (int i = 0; i < 3; i++) begin
      cyc(); settle();
      check("rst_outs_a", 32'(outs_a), 32'h0);
      check("rst_outs_b", 32'(outs_b), 32'h0);
    end
    rst = 1'b1;
    ia.hit_vec = 2'b01; ia.valid_vec = 2'b01; ia.dram_ack = 1'b0;
    ib.cpu_req = 1'b0; ib.dram_ack = 1'b0;
    cyc(); ia.cpu_req = 1'b0; settle();
    check("post_rst_ack", 32'(ia.cpu_ack), 32'd1);
    check("post_rst_way", 32'(ia.way_sel), 32'd0);
    cyc(); settle();
    check("post_rst_ack_low", 32'(ia.cpu_ack), 32'd0);

    // 2: read hit in way 1
    ia.cpu_req = 1'b1; ia.cpu_we = 1'b0; ia.hit_vec = 2'b10; ia.valid_vec = 2'b11;
    cyc(); ia.cpu_req = 1'b0; settle();
    check("rhit_ack", 32'(ia.cpu_ack), 32'd1);
    check("rhit_way", 32'(ia.way_sel), 32'd1);
    check("rhit_cs", 32'(ia.dram_cs), 32'd0);
    cyc(); settle();
    check("rhit_ack_once", 32'(ia.cpu_ack), 32'd0);
    check("rhit_cs_idle", 32'(ia.dram_cs), 32'd0);

    // 3: read miss into invalid way 1, gapped fill
    ia.cpu_req = 1'b1; ia.hit_vec = 2'b00; ia.valid_vec = 2'b01; ia.dirty_vec = 2'b00;
    cyc(); ia.cpu_req = 1'b0; settle();
    check("rmiss_way", 32'(ia.way_sel), 32'd1);
    check("rmiss_noack", 32'(ia.cpu_ack), 32'd0);
    cyc();
    for (int b = 0; b < 4; b++) begin
      ia.dram_ack = 1'b0; settle();
      check("fill_gap", 32'({ia.dram_cs, ia.dram_we, ia.sram_we, ia.sram_data_sel}), 32'b1001);
      check("fill_gap_beat", 32'(ia.beat), 32'(b));
      cyc(); ia.dram_ack = 1'b1; settle();
      check("fill_we", 32'(ia.sram_we), 32'd1);
      check("fill_beat", 32'(ia.beat), 32'(b));
      check("fill_way", 32'(ia.way_sel), 32'd1);
      cyc();
    end
    ia.dram_ack = 1'b0; settle();
    check("fdone_tag", 32'({ia.tag_we, ia.valid_o, ia.dirty_o, ia.dram_cs}), 32'b1100);
    check("fdone_beat", 32'(ia.beat), 32'd0);
    cyc(); settle();
    check("resp_ack", 32'(ia.cpu_ack), 32'd1);
    cyc(); settle();
    check("resp_ack_low", 32'(ia.cpu_ack), 32'd0);

    // 4: write miss, all valid, rr victim 0 dirty -> WB then FILL then WRITE_HIT
    ia.cpu_req = 1'b1; ia.cpu_we = 1'b1; ia.valid_vec = 2'b11; ia.dirty_vec = 2'b01;
    cyc(); ia.cpu_req = 1'b0; settle();
    check("wmiss_way_rr0", 32'(ia.way_sel), 32'd0);
    cyc();
    for (int b = 0; b < 4; b++) begin
      ia.dram_ack = 1'b1; settle();
      check("wb_ctrl", 32'({ia.dram_cs, ia.dram_we, ia.dram_addr_sel, ia.sram_we}), 32'b1110);
      check("wb_beat", 32'(ia.beat), 32'(b));
      cyc();
    end
    for (int b = 0; b < 4; b++) begin
      settle();
      check("wfill_ctrl", 32'({ia.dram_cs, ia.dram_we, ia.dram_addr_sel, ia.sram_we}), 32'b1001);
      check("wfill_beat", 32'(ia.beat), 32'(b));
      cyc();
    end
    ia.dram_ack = 1'b0; settle();
    check("wfdone_tag", 32'({ia.tag_we, ia.valid_o, ia.dirty_o}), 32'b110);
    cyc(); settle();
    check("whit_ctrl", 32'({ia.sram_we, ia.sram_data_sel, ia.tag_we, ia.valid_o, ia.dirty_o}),
          32'b10111);
    check("whit_ack", 32'(ia.cpu_ack), 32'd1);
    check("whit_way", 32'(ia.way_sel), 32'd0);
    cyc(); settle();
    check("whit_idle", 32'(ia.cpu_ack), 32'd0);

    // 6: rr_ptr advanced to 1; reset mid-fill, then restart with rr_ptr back at 0
    ia.cpu_req = 1'b1; ia.cpu_we = 1'b0; ia.dirty_vec = 2'b00;
    cyc(); ia.cpu_req = 1'b0; settle();
    check("rr_adv_way", 32'(ia.way_sel), 32'd1);
    cyc(); ia.dram_ack = 1'b1;
    cyc(); settle();
    check("abort_beat1", 32'(ia.beat), 32'd1);
    cyc(); ia.dram_ack = 1'b0; rst = 1'b0;
    cyc(); settle();
    check("abort_cs", 32'(ia.dram_cs), 32'd0);
    check("abort_beat", 32'(ia.beat), 32'd0);
    check("abort_tag", 32'(ia.tag_we), 32'd0);
    rst = 1'b1;
    cyc(); settle();
    check("abort_idle_tag", 32'(ia.tag_we), 32'd0);
    ia.cpu_req = 1'b1;
    cyc(); ia.cpu_req = 1'b0; settle();
    check("restart_way_rr", 32'(ia.way_sel), 32'd0);
    cyc(); ia.dram_ack = 1'b1;
    for (int b = 0; b < 4; b++) begin
      settle();
      check("restart_beat", 32'(ia.beat), 32'(b));
      check("restart_we", 32'(ia.sram_we), 32'd1);
      cyc();
    end
    ia.dram_ack = 1'b0; settle();
    check("restart_tag", 32'(ia.tag_we), 32'd1);
    cyc(); settle();
    check("restart_ack", 32'(ia.cpu_ack), 32'd1);
    cyc();

    // 5: write-through write hit, DRAM ack after 5 cycles
    ib.cpu_req = 1'b1; ib.cpu_we = 1'b1; ib.hit_vec = 2'b01; ib.valid_vec = 2'b01;
    ib.dirty_vec = 2'b01;
    cyc(); ib.cpu_req = 1'b0; settle();
    check("wt_cmp_ack", 32'(ib.cpu_ack), 32'd0);
    check("wt_cmp_way", 32'(ib.way_sel), 32'd0);
    cyc(); settle();
    check("wt_hit_ctrl", 32'({ib.sram_we, ib.sram_data_sel, ib.tag_we, ib.valid_o, ib.dirty_o}),
          32'b10110);
    check("wt_hit_noack", 32'({ib.cpu_ack, ib.dram_cs}), 32'b00);
    cyc();
    for (int i = 0; i < 5; i++) begin
      ib.dram_ack = (i == 4);
      settle();
      check("wt_mem_ctrl", 32'({ib.dram_cs, ib.dram_we, ib.dram_addr_sel, ib.cpu_ack}), 32'b1100);
      cyc();
    end
    ib.dram_ack = 1'b0; settle();
    check("wt_resp", 32'({ib.cpu_ack, ib.dram_cs}), 32'b10);
    cyc(); settle();
    check("wt_idle", 32'(ib.cpu_ack), 32'd0);

    // write-through never writes back, even when the victim is dirty
    ib.cpu_req = 1'b1; ib.cpu_we = 1'b0; ib.hit_vec = 2'b00; ib.valid_vec = 2'b11;
    ib.dirty_vec = 2'b11;
    cyc(); ib.cpu_req = 1'b0; settle();
    check("wt_miss_way", 32'(ib.way_sel), 32'd0);
    cyc(); settle();
    check("wt_miss_fill", 32'({ib.dram_cs, ib.dram_we, ib.dram_addr_sel, ib.sram_data_sel}),
          32'b1001);
    rst = 1'b0;
    cyc(); rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
